hex_marquee_scroller: RTL and testbench

- Parametrised seven-segment marquee. Scrolls a writable message of MSG_LEN glyphs across NUM_DIGITS active-low HEX displays.
- Supports left/right scroll direction, pause, and a runtime speed setting adjusted by held active-low keys.
- Sits between board switch/key inputs and the HEX display pins. Successor to the fixed 4-digit, single-direction scroller.

---
 rtl/hex_marquee_scroller_if.sv | 19 +
 rtl/hex_marquee_scroller.sv | 143 ++++++++++++++
 tb/tb_hex_marquee_scroller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_marquee_scroller_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_marquee_scroller_if
// Brief    : Glyph write port of the marquee message buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface hex_marquee_scroller_if #(
  parameter int MSG_LEN = 8
);
  localparam int c_ADDR_W = $clog2(MSG_LEN);

  logic                wr_en;
  logic [c_ADDR_W-1:0] wr_addr;
  logic [6:0]          wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface
`default_nettype wire

// File: rtl/hex_marquee_scroller.sv
`default_nettype none
// ============================================================================
// Module   : hex_marquee_scroller
// Brief    : Scrolls a writable glyph buffer across active-low HEX digits.
// Revision : 1.0 - initial release
// ============================================================================
module hex_marquee_scroller #(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_LEN       = 8,
  parameter int ACC_WIDTH     = 26,
  parameter int THRESHOLD     = 50000000,
  parameter int SPEED_DEFAULT = 3,
  parameter int SPEED_MIN     = 1,
  parameter int SPEED_MAX     = 51,
  parameter int RAMP_LOG2     = 21
) (
  input  wire logic                    CLOCK_50,
  input  wire logic                    RESET,
  hex_marquee_scroller_if.slave        wr_bus,
  input  wire logic                    load,
  input  wire logic                    dir,
  input  wire logic                    pause,
  input  wire logic                    speed_rst_n,
  input  wire logic                    speed_up_n,
  input  wire logic                    speed_dn_n,
  output logic [7*NUM_DIGITS-1:0]      hex_out,
  output logic                         step,
  output logic [7:0]                   speed
);

  localparam int                   c_ADDR_W        = $clog2(MSG_LEN);
  localparam logic [c_ADDR_W-1:0]  c_OFF_LAST      = c_ADDR_W'(MSG_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] c_THRESHOLD     = ACC_WIDTH'(THRESHOLD);
  localparam logic [7:0]           c_SPEED_DEFAULT = 8'(SPEED_DEFAULT);
  localparam logic [7:0]           c_SPEED_MIN     = 8'(SPEED_MIN);
  localparam logic [7:0]           c_SPEED_MAX     = 8'(SPEED_MAX);

  logic [6:0]              r_buf [MSG_LEN];
  logic [c_ADDR_W-1:0]     r_offset;
  logic [c_ADDR_W-1:0]     w_offset_next;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [RAMP_LOG2-1:0]    r_ramp;
  logic [7:0]              r_speed;
  logic                    r_step;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [7*NUM_DIGITS-1:0] w_hex;
  logic                    w_wr_ok;
  logic                    w_acc_full;
  logic                    w_ramp_tick;

  assign w_wr_ok     = wr_bus.wr_en && (32'(wr_bus.wr_addr) < MSG_LEN);
  assign w_acc_full  = (r_acc >= c_THRESHOLD);
  assign w_ramp_tick = (r_ramp == '0);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_buf[i] <= 7'h7F;
      end
    end else if (w_wr_ok) begin
      r_buf[wr_bus.wr_addr] <= wr_bus.wr_data;
    end
  end

  // Offset is a modulo-MSG_LEN counter; dir only matters on a step cycle.
  always_comb begin
    w_offset_next = r_offset;
    if (dir) begin
      w_offset_next = (r_offset == '0) ? c_OFF_LAST : r_offset - 1'b1;
    end else begin
      w_offset_next = (r_offset == c_OFF_LAST) ? '0 : r_offset + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_acc    <= '0;
      r_offset <= '0;
      r_step   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (load) begin
        r_acc    <= '0;
        r_offset <= '0;
      end else if (pause) begin
        r_acc    <= r_acc;
        r_offset <= r_offset;
      end else if (w_acc_full) begin
        r_acc    <= '0;
        r_offset <= w_offset_next;
        r_step   <= 1'b1;
      end else begin
        r_acc <= r_acc + ACC_WIDTH'(r_speed);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_ramp <= '0;
    end else begin
      r_ramp <= r_ramp + 1'b1;
    end
  end

  // A held up key blocks the down key even when up is already saturated.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_speed <= c_SPEED_DEFAULT;
    end else if (!speed_rst_n) begin
      r_speed <= c_SPEED_DEFAULT;
    end else if (w_ramp_tick) begin
      if (!speed_up_n) begin
        if (r_speed < c_SPEED_MAX) begin
          r_speed <= r_speed + 8'd1;
        end
      end else if (!speed_dn_n && (r_speed > c_SPEED_MIN)) begin
        r_speed <= r_speed - 8'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int c_SHIFT = NUM_DIGITS - 1 - k;
    logic [c_ADDR_W-1:0] w_idx;
    assign w_idx             = c_ADDR_W'((int'(r_offset) + c_SHIFT) % MSG_LEN);
    assign w_hex[7*k +: 7]   = r_buf[w_idx];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_hex;
    end
  end

  assign hex_out = r_hex;
  assign step    = r_step;
  assign speed   = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_hex_marquee_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_marquee_scroller
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_marquee_scroller;

  localparam int NUM_DIGITS    = 4;
  localparam int MSG_LEN       = 6;
  localparam int ACC_WIDTH     = 8;
  localparam int THRESHOLD     = 10;
  localparam int SPEED_DEFAULT = 3;
  localparam int SPEED_MIN     = 1;
  localparam int SPEED_MAX     = 51;
  localparam int RAMP_LOG2     = 3;
  localparam int HW            = 7 * NUM_DIGITS;
  localparam logic [6:0] BL    = 7'h7F;
  localparam logic [6:0] G [MSG_LEN] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

  logic          CLOCK_50 = 1'b0;
  logic          RESET, load, dir, pause, speed_rst_n, speed_up_n, speed_dn_n;
  logic [HW-1:0] hex_out;
  logic          step;
  logic [7:0]    speed;

  hex_marquee_scroller_if #(.MSG_LEN(MSG_LEN)) wr_bus ();

  hex_marquee_scroller #(
    .NUM_DIGITS(NUM_DIGITS), .MSG_LEN(MSG_LEN), .ACC_WIDTH(ACC_WIDTH),
    .THRESHOLD(THRESHOLD), .SPEED_DEFAULT(SPEED_DEFAULT), .SPEED_MIN(SPEED_MIN),
    .SPEED_MAX(SPEED_MAX), .RAMP_LOG2(RAMP_LOG2)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .wr_bus(wr_bus),
    .load(load), .dir(dir), .pause(pause),
    .speed_rst_n(speed_rst_n), .speed_up_n(speed_up_n), .speed_dn_n(speed_dn_n),
    .hex_out(hex_out), .step(step), .speed(speed)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Reference model: message as an array, scroll position as a plain integer.
  logic [6:0]    m_buf [MSG_LEN];
  int            m_off, m_acc, m_speed, m_ramp;
  logic          m_step;
  logic [HW-1:0] m_hex;

  typedef struct {
    logic          wr_en;
    logic [2:0]    addr;
    logic [6:0]    data;
    logic [HW-1:0] exp_hex;
    logic          exp_step;
    logic [7:0]    exp_speed;
  } vec_t;
  vec_t vt [8];

  function automatic logic [HW-1:0] digits(logic [6:0] d3, logic [6:0] d2,
                                           logic [6:0] d1, logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MSG_LEN; i++) m_buf[i] = BL;
    m_off = 0; m_acc = 0; m_speed = SPEED_DEFAULT; m_ramp = 0;
    m_step = 1'b0; m_hex = '1;
  endtask

  task automatic model_edge();
    logic [HW-1:0] nh;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nh[7*k +: 7] = m_buf[(m_off + NUM_DIGITS - 1 - k) % MSG_LEN];
    end
    m_hex = nh;
    if (wr_bus.wr_en && int'(wr_bus.wr_addr) < MSG_LEN) m_buf[wr_bus.wr_addr] = wr_bus.wr_data;
    m_step = 1'b0;
    if (load) begin
      m_acc = 0; m_off = 0;
    end else if (!pause) begin
      if (m_acc >= THRESHOLD) begin
        m_acc  = 0;
        m_step = 1'b1;
        m_off  = dir ? (m_off + MSG_LEN - 1) % MSG_LEN : (m_off + 1) % MSG_LEN;
      end else begin
        m_acc = m_acc + m_speed;
      end
    end
    if (!speed_rst_n) m_speed = SPEED_DEFAULT;
    else if (m_ramp == 0) begin
      if (!speed_up_n) m_speed = (m_speed < SPEED_MAX) ? m_speed + 1 : m_speed;
      else if (!speed_dn_n) m_speed = (m_speed > SPEED_MIN) ? m_speed - 1 : m_speed;
    end
    m_ramp = (m_ramp + 1) % (1 << RAMP_LOG2);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check("hex_out", 64'(hex_out), 64'(m_hex));
    check("step", 64'(step), 64'(m_step));
    check("speed", 64'(speed), 64'(m_speed));
  endtask

  task automatic wait_step(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < limit);
    if (step !== 1'b1) n = -1;
  endtask

  task automatic wait_model_off(input int off, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      if (m_step && m_off == off) found = 1'b1;
    end
  endtask

  initial begin
    int  n, steps_seen;
    bit  found;

    vt[0] = '{1'b1, 3'd0, G[0], digits(BL, BL, BL, BL),       1'b0, 8'd3};
    vt[1] = '{1'b1, 3'd1, G[1], digits(G[0], BL, BL, BL),     1'b0, 8'd3};
    vt[2] = '{1'b1, 3'd2, G[2], digits(G[0], G[1], BL, BL),   1'b0, 8'd3};
    vt[3] = '{1'b1, 3'd3, G[3], digits(G[0], G[1], G[2], BL), 1'b0, 8'd3};
    vt[4] = '{1'b1, 3'd4, G[4], digits(G[0], G[1], G[2], G[3]), 1'b0, 8'd3};
    vt[5] = '{1'b1, 3'd5, G[5], digits(G[0], G[1], G[2], G[3]), 1'b0, 8'd3};
    vt[6] = '{1'b1, 3'd7, 7'h00, digits(G[0], G[1], G[2], G[3]), 1'b0, 8'd3};
    vt[7] = '{1'b0, 3'd0, 7'h00, digits(G[0], G[1], G[2], G[3]), 1'b0, 8'd3};

    RESET = 1'b1; load = 1'b0; dir = 1'b0; pause = 1'b1;
    speed_rst_n = 1'b1; speed_up_n = 1'b1; speed_dn_n = 1'b1;
    wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;
    model_reset();
    #2;
    check("reset_hex", 64'(hex_out), 64'({HW{1'b1}}));
    check("reset_step", 64'(step), 64'd0);
    check("reset_speed", 64'(speed), 64'd3);
    #10 RESET = 1'b0;

    // Fill the message while paused so the view stays at offset 0.
    for (int i = 0; i < 8; i++) begin
      wr_bus.wr_en = vt[i].wr_en; wr_bus.wr_addr = vt[i].addr; wr_bus.wr_data = vt[i].data;
      tick();
      check($sformatf("vec%0d_hex", i), 64'(hex_out), 64'(vt[i].exp_hex));
      check($sformatf("vec%0d_step", i), 64'(step), 64'(vt[i].exp_step));
      check($sformatf("vec%0d_speed", i), 64'(speed), 64'(vt[i].exp_speed));
    end
    wr_bus.wr_en = 1'b0;

    pause = 1'b0;
    wait_step(30, n);
    check("first_step_latency", 64'(n), 64'd5);
    wait_step(30, n);
    check("step_period", 64'(n), 64'd5);
    wait_model_off(5, 60, found);
    check("reach_offset5", 64'(found), 64'd1);
    tick();
    check("offset5_view", 64'(hex_out), 64'(digits(G[5], G[0], G[1], G[2])));

    wait_model_off(0, 30, found);
    check("left_wrap", 64'(found), 64'd1);
    dir = 1'b1;
    wait_step(30, n);
    tick();
    check("right_wrap_view", 64'(hex_out), 64'(digits(G[5], G[0], G[1], G[2])));

    wait_step(30, n);
    tick(); tick();
    pause = 1'b1;
    steps_seen = 0;
    repeat (20) begin
      tick();
      if (step === 1'b1) steps_seen++;
    end
    check("pause_no_step", 64'(steps_seen), 64'd0);
    pause = 1'b0;
    wait_step(30, n);
    check("pause_resume_remaining", 64'(n), 64'd3);

    speed_up_n = 1'b0;
    repeat (400) tick();
    check("speed_ceiling", 64'(speed), 64'd51);
    speed_dn_n = 1'b0;
    repeat (24) tick();
    check("both_keys_at_max", 64'(speed), 64'd51);
    speed_up_n = 1'b1;
    repeat (450) tick();
    check("speed_floor", 64'(speed), 64'd1);
    speed_dn_n = 1'b1;
    speed_rst_n = 1'b0;
    tick();
    check("speed_restore", 64'(speed), 64'd3);
    speed_rst_n = 1'b1;

    wait_step(60, n);
    tick(); tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("load_view", 64'(hex_out), 64'(digits(G[0], G[1], G[2], G[3])));
    wait_step(30, n);
    check("load_to_step", 64'(n), 64'd4);

    repeat (1500) begin
      pause          = ($urandom_range(0, 3) == 0);
      load           = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      wr_bus.wr_en   = ($urandom_range(0, 5) == 0);
      wr_bus.wr_addr = 3'($urandom_range(0, 7));
      wr_bus.wr_data = 7'($urandom);
      speed_up_n     = ($urandom_range(0, 2) != 0);
      speed_dn_n     = ($urandom_range(0, 2) != 0);
      speed_rst_n    = ($urandom_range(0, 63) != 0);
      tick();
    end
    load = 1'b0; pause = 1'b0; wr_bus.wr_en = 1'b0;
    speed_up_n = 1'b1; speed_dn_n = 1'b1; speed_rst_n = 1'b1;

    // Reset lands between edges and must act without a clock.
    tick();
    #3 RESET = 1'b1;
    #1;
    check("async_reset_hex", 64'(hex_out), 64'({HW{1'b1}}));
    check("async_reset_step", 64'(step), 64'd0);
    check("async_reset_speed", 64'(speed), 64'd3);
    model_reset();
    #2 RESET = 1'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
